// File: rtl/acc_uart_tx.sv
// acc_uart_tx
//   Serialises accumulator write events onto a UART-style line. Each sample
//   goes into a small FIFO, so the processor never has to wait for the slow
//   serial line. Frame format: start(0), 8 data bits LSB first, optional even
//   parity bit, stop(1). Each bit lasts CLKS_PER_BIT cycles.
//
//   Build option: define ACC_TX_PARITY_EN to insert an even-parity bit
//   between data bit 7 and the stop bit (11-bit frames instead of 10).
//
// Ports
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   acc        : accumulator value
//   acc_we     : one-cycle strobe, acc is to be transmitted
//   tx         : serial line (registered, idles high)
//   tx_busy    : a frame is on the line
//   fifo_empty : FIFO holds no entries
//   fifo_full  : FIFO holds FIFO_DEPTH entries
//   overflow   : sticky, a sample was dropped because the FIFO was full
module acc_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] acc,
    input  logic       acc_we,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_empty,
    output logic       fifo_full,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_q, shift_d;
    logic            tx_d;
    logic            baud_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;

`ifdef ACC_TX_PARITY_EN
    logic            par_q;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign tx_busy    = (state_q != IDLE);
    assign baud_end   = (baud_cnt == BW'(CLKS_PER_BIT - 1));

    // The FSM only looks at registered occupancy, so a sample pushed while
    // idle is picked up one cycle later (no bypass path).
    assign pop  = !fifo_empty &&
                  ((state_q == IDLE) || (state_q == STOP && baud_end));
    // A full FIFO still accepts a sample on the cycle it frees a slot.
    assign push = acc_we && (!fifo_full || pop);

    // ---------------- state register + datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            tx      <= tx_d;
            shift_q <= shift_d;

            if (state_q == IDLE || baud_end) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + 1'b1;

            if (state_q != DATA)  bit_cnt <= '0;
            else if (baud_end)    bit_cnt <= bit_cnt + 1'b1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (acc_we && !push) overflow <= 1'b1;
        end
    end

    // Storage needs no reset: occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= acc;
    end

`ifdef ACC_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)      par_q <= 1'b0;
        else if (pop) par_q <= ^mem[rd_ptr];
    end
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!fifo_empty) state_d = START;
            START:  if (baud_end) state_d = DATA;
            DATA:   if (baud_end && bit_cnt == 3'd7)
`ifdef ACC_TX_PARITY_EN
                        state_d = PARITY;
            PARITY: if (baud_end) state_d = STOP;
`else
                        state_d = STOP;
`endif
            STOP:   if (baud_end) state_d = fifo_empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // tx is registered from the value the line should carry in the next
    // state, so it changes on the same edge as the state.
    always_comb begin
        shift_d = shift_q;
        if (pop)
            shift_d = mem[rd_ptr];
        else if (state_q == DATA && baud_end)
            shift_d = {1'b0, shift_q[7:1]};

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef ACC_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_acc_uart_tx.sv
module tb_acc_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef ACC_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL   = NB * CPB;
    localparam int MAXT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] acc = '0;
    logic       acc_we = 1'b0;
    logic       tx, tx_busy, fifo_empty, fifo_full, overflow;

    int total = 0;
    int bad   = 0;

    // stimulus table (indexed by edge number within a scenario)
    bit         w_en [MAXT];
    logic [7:0] w_d  [MAXT];
    // expected values just after each edge
    bit         e_tx [MAXT];
    bit         e_busy [MAXT];
    bit         e_empty [MAXT];
    bit         e_ovf [MAXT];

    acc_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .acc(acc), .acc_we(acc_we), .tx(tx),
        .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Line level at cycle i of a frame carrying d.
    function automatic bit frame_bit(input logic [7:0] d, input int i);
        int b;
        b = i / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef ACC_TX_PARITY_EN
        if (b == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Transaction-level reference: a queue of samples and a line that is
    // either free or carrying a frame that ends FL cycles after its pop.
    task automatic model_run(input int T);
        logic [7:0] q[$];
        logic [7:0] cur;
        bit act, ovf, pop;
        int s, fend;
        act = 0; ovf = 0; s = 0; fend = 0; cur = '0;
        for (int t = 0; t < T; t++) begin
            pop = 0;
            if (q.size() > 0 && (!act || t == fend)) pop = 1;
            if (act && t == fend && !pop) act = 0;
            if (pop) begin
                cur = q.pop_front(); s = t; fend = t + FL; act = 1;
            end
            if (w_en[t]) begin
                if (q.size() < DEPTH || pop) q.push_back(w_d[t]);
                else ovf = 1;
            end
            e_empty[t] = (q.size() == 0);
            e_ovf[t]   = ovf;
            e_busy[t]  = act;
            e_tx[t]    = act ? frame_bit(cur, t - s) : 1'b1;
        end
    endtask

    task automatic clear_tbl();
        for (int t = 0; t < MAXT; t++) begin
            w_en[t] = 0; w_d[t] = 8'($urandom);
        end
    endtask

    task automatic apply_reset();
        acc_we = 0; rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        acc_we = 0; rst = 1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (tx_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", fifo_empty); end
        total++; if (fifo_full !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        rst = 0;
    endtask

    task automatic test_single();
        int T;
        apply_reset(); clear_tbl();
        w_en[0] = 1; w_d[0] = 8'hA5;
        w_en[FL + 5] = 1;                      // random byte after a short idle gap
        T = 2 * FL + 10;
        model_run(T);
        for (int t = 0; t < T; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL single_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
            total++; if (tx_busy !== e_busy[t]) begin bad++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, tx_busy, e_busy[t]); end
            total++; if (fifo_empty !== e_empty[t]) begin bad++; $display("FAIL single_empty t=%0d got=%b exp=%b", t, fifo_empty, e_empty[t]); end
        end
    endtask

    task automatic test_burst();
        int T;
        apply_reset(); clear_tbl();
        for (int i = 0; i < 4; i++) begin w_en[i] = 1; w_d[i] = 8'(i + 1); end
        T = 4 * FL + 10;
        model_run(T);
        for (int t = 0; t < T; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL burst_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
            total++; if (tx_busy !== e_busy[t]) begin bad++; $display("FAIL burst_busy t=%0d got=%b exp=%b", t, tx_busy, e_busy[t]); end
            total++; if (fifo_empty !== e_empty[t]) begin bad++; $display("FAIL burst_empty t=%0d got=%b exp=%b", t, fifo_empty, e_empty[t]); end
        end
    endtask

    task automatic test_overflow();
        int T;
        apply_reset(); clear_tbl();
        for (int i = 0; i < 6; i++) begin w_en[i] = 1; w_d[i] = 8'(8'h10 + i); end
        T = 5 * FL + 10;
        model_run(T);
        for (int t = 0; t < T; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL ovf_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
            total++; if (overflow !== e_ovf[t]) begin bad++; $display("FAIL ovf_flag t=%0d got=%b exp=%b", t, overflow, e_ovf[t]); end
            total++; if (fifo_full !== (t >= 4 && t < FL + 1)) begin bad++; $display("FAIL ovf_full t=%0d got=%b", t, fifo_full); end
        end
        apply_reset();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_push_full_pop();
        int T;
        apply_reset(); clear_tbl();
        for (int i = 0; i < 5; i++) begin w_en[i] = 1; w_d[i] = 8'(8'h20 + i); end
        w_en[FL + 1] = 1; w_d[FL + 1] = 8'h3C;  // lands on the STOP pop edge
        T = 6 * FL + 10;
        model_run(T);
        for (int t = 0; t < T; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL pfp_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL pfp_ovf t=%0d got=%b exp=0", t, overflow); end
            total++; if (fifo_empty !== e_empty[t]) begin bad++; $display("FAIL pfp_empty t=%0d got=%b exp=%b", t, fifo_empty, e_empty[t]); end
        end
    endtask

    task automatic test_mid_reset();
        int rt;
        apply_reset(); clear_tbl();
        w_en[0] = 1; w_d[0] = 8'hFF;
        w_en[1] = 1; w_en[2] = 1;
        rt = 1 + CPB + 3 * CPB + 1;            // an edge inside data bit 3
        model_run(rt);
        for (int t = 0; t < rt; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL mrst_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
        end
        rst = 1;
        @(posedge clk); #1 rst = 0;
        total++; if (tx !== 1'b1)         begin bad++; $display("FAIL mrst_tx_now got=%b exp=1", tx); end
        total++; if (fifo_empty !== 1'b1) begin bad++; $display("FAIL mrst_empty got=%b exp=1", fifo_empty); end
        total++; if (tx_busy !== 1'b0)    begin bad++; $display("FAIL mrst_busy got=%b exp=0", tx_busy); end
        for (int t = 0; t < 3 * FL; t++) begin
            @(posedge clk); #1;
            total++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin bad++; $display("FAIL mrst_quiet t=%0d tx=%b busy=%b exp tx=1 busy=0", t, tx, tx_busy); end
        end
    endtask

    task automatic test_random();
        int T;
        apply_reset(); clear_tbl();
        for (int t = 0; t < 400; t++) w_en[t] = ($urandom_range(0, 24) == 0);
        for (int t = 100; t < 108; t++) w_en[t] = 1;   // forced burst to hit overflow
        T = 400 + (DEPTH + 2) * FL;
        model_run(T);
        for (int t = 0; t < T; t++) begin
            acc = w_d[t]; acc_we = w_en[t];
            @(posedge clk); #1 acc_we = 0;
            total++; if (tx !== e_tx[t]) begin bad++; $display("FAIL rand_tx t=%0d got=%b exp=%b", t, tx, e_tx[t]); end
            total++; if (tx_busy !== e_busy[t]) begin bad++; $display("FAIL rand_busy t=%0d got=%b exp=%b", t, tx_busy, e_busy[t]); end
            total++; if (fifo_empty !== e_empty[t]) begin bad++; $display("FAIL rand_empty t=%0d got=%b exp=%b", t, fifo_empty, e_empty[t]); end
            total++; if (overflow !== e_ovf[t]) begin bad++; $display("FAIL rand_ovf t=%0d got=%b exp=%b", t, overflow, e_ovf[t]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_push_full_pop();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
